// File: rtl/uart_rx_core_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_rx_core_pkg
// Brief    : Shared UART defaults and receiver state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_core_pkg;

  // Line rate defaults shared with the transmitter (50 MHz / 115200).
  localparam int c_DEF_CLKS_PER_BIT = 434;
  localparam int c_DEF_DATA_BITS    = 8;

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_START     = 3'd1;
  localparam logic [2:0] c_ST_DATA      = 3'd2;
  localparam logic [2:0] c_ST_PARITY    = 3'd3;
  localparam logic [2:0] c_ST_STOP      = 3'd4;
  localparam logic [2:0] c_ST_WAIT_HIGH = 3'd5;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Brief    : Multi-flop synchronizer, resets to 1 (idle line level).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : UART receiver, mid-bit sampling, framing/overrun flags, single
//            holding register. Define UART_RX_PARITY_EN for an even parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = c_DEF_DATA_BITS
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic                 uart_rx,
  input  logic                 uart_rd_i,
  output logic [DATA_BITS-1:0] uart_dat_o,
  output logic                 done,
  output logic                 uart_rx_busy,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);

  localparam int c_CW = $clog2(CLKS_PER_BIT);
  localparam int c_BW = $clog2(DATA_BITS + 1);
  localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_BW-1:0] c_LAST = c_BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_bit_tick;
  logic [2:0]           r_state;
  logic [c_CW-1:0]      r_clk_cnt;
  logic [c_BW-1:0]      r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dat;
  logic                 r_done;
  logic                 r_frame_err;
  logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_err;
  logic                 r_par_bad;
`endif

  uart_rx_sync #(
    .STAGES (2)
  ) u_sync (
    .clk (sys_clk_i),
    .rst (sys_rst_i),
    .i_d (uart_rx),
    .o_q (w_rx_s)
  );

  assign w_bit_tick = (r_clk_cnt == c_FULL);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state     <= c_ST_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_dat       <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err   <= 1'b0;
      r_par_bad   <= 1'b0;
`endif
    end else begin
      // Host read comes first so a same-edge completion below can override it.
      if (uart_rd_i) begin
        r_done      <= 1'b0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_par_err   <= 1'b0;
`endif
      end

      case (r_state)
        c_ST_IDLE: begin
          if (!w_rx_s) begin
            r_state   <= c_ST_START;
            r_clk_cnt <= '0;
          end
        end

        c_ST_START: begin
          if (r_clk_cnt == c_HALF) begin
            r_clk_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= c_ST_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state   <= c_ST_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + c_CW'(1);
          end
        end

        c_ST_DATA: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == c_LAST) begin
              r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= c_ST_PARITY;
`else
              r_state   <= c_ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + c_BW'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + c_CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        c_ST_PARITY: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            r_par_bad <= (^r_shift) ^ w_rx_s;
            r_state   <= c_ST_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + c_CW'(1);
          end
        end
`endif

        c_ST_STOP: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              r_dat   <= r_shift;
              r_done  <= 1'b1;
              if (r_done && !uart_rd_i) begin
                r_overrun <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                r_par_err <= 1'b1;
              end
`endif
              r_state <= c_ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= c_ST_WAIT_HIGH;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + c_CW'(1);
          end
        end

        // A held-low line (break) must return high before a new start is armed.
        c_ST_WAIT_HIGH: begin
          if (w_rx_s) begin
            r_state <= c_ST_IDLE;
          end
        end

        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign uart_dat_o   = r_dat;
  assign done         = r_done;
  assign uart_rx_busy = (r_state != c_ST_IDLE);
  assign frame_err    = r_frame_err;
  assign overrun      = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Directed self-checking bench for uart_rx_core (8N1, 434 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int c_CPB = 434;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rd;
  logic [7:0] dat;
  logic       done;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_fall   = 0;
  int done_rise = 0;
  int busy_rise = 0;
  logic done_prev = 1'b0;
  logic busy_prev = 1'b0;

  uart_rx_core #(
    .CLKS_PER_BIT (c_CPB),
    .DATA_BITS    (8)
  ) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .uart_rx      (rx),
    .uart_rd_i    (rd),
    .uart_dat_o   (dat),
    .done         (done),
    .uart_rx_busy (busy),
    .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done && !done_prev) done_rise <= cyc;
    if (busy && !busy_prev) busy_rise <= cyc;
    done_prev <= done;
    busy_prev <= busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Leaves the line at the stop-bit level, #1 after the last bit-period edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(posedge clk); #1;
    rx     = 1'b0;
    t_fall = cyc;
    repeat (c_CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (c_CPB) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (c_CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_pulse();
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    rd  = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_dat",   dat,       32'h0);
    check("rst_done",  done,      32'h0);
    check("rst_busy",  busy,      32'h0);
    check("rst_ferr",  frame_err, 32'h0);
    check("rst_ovr",   overrun,   32'h0);
    @(posedge clk); #1 rst = 1'b0;
    idle(10);

    // Basic frame and latency
    send_frame(8'h75, 1'b1);
    @(negedge clk);
    check("b75_busy_lat", busy_rise - t_fall, 32'd3);
    check("b75_latency",  done_rise - t_fall, 32'd4126);
    check("b75_dat",      dat,       32'h75);
    check("b75_done",     done,      32'h1);
    check("b75_ferr",     frame_err, 32'h0);
    rd_pulse();
    check("b75_rd_done",  done,      32'h0);
    idle(10);

    // Start-bit glitch
    @(posedge clk); #1 rx = 1'b0;
    t_fall = cyc;
    repeat (100) @(posedge clk);
    #1 rx = 1'b1;
    idle(300);
    @(negedge clk);
    check("gl_busy_pulse", busy_rise - t_fall, 32'd3);
    check("gl_busy",  busy,      32'h0);
    check("gl_done",  done,      32'h0);
    check("gl_ferr",  frame_err, 32'h0);
    check("gl_ovr",   overrun,   32'h0);
    send_frame(8'hA5, 1'b1);
    @(negedge clk);
    check("bA5_dat",  dat,  32'hA5);
    check("bA5_done", done, 32'h1);
    rd_pulse();
    idle(10);

    // Stop bit low followed by a held-low break
    send_frame(8'h00, 1'b0);
    idle(2000);
    @(negedge clk);
    check("brk_busy", busy,      32'h1);
    check("brk_ferr", frame_err, 32'h1);
    @(posedge clk); #1 rx = 1'b1;
    idle(10);
    @(negedge clk);
    check("brk_idle", busy,      32'h0);
    check("brk_done", done,      32'h0);
    check("brk_dat",  dat,       32'hA5);
    send_frame(8'h3C, 1'b1);
    @(negedge clk);
    check("b3C_dat",  dat,       32'h3C);
    check("b3C_done", done,      32'h1);
    check("b3C_ferr_sticky", frame_err, 32'h1);
    rd_pulse();
    check("b3C_rd_ferr", frame_err, 32'h0);
    check("b3C_rd_done", done,      32'h0);
    idle(10);

    // Overrun without read
    send_frame(8'h1B, 1'b1);
    idle(10);
    send_frame(8'h1E, 1'b1);
    @(negedge clk);
    check("ovr_dat",  dat,     32'h1E);
    check("ovr_done", done,    32'h1);
    check("ovr_flag", overrun, 32'h1);
    rd_pulse();
    check("ovr_rd_done", done,    32'h0);
    check("ovr_rd_flag", overrun, 32'h0);
    idle(10);

    // Read on the completion edge of the second byte
    send_frame(8'h1B, 1'b1);
    idle(10);
    fork
      send_frame(8'h1E, 1'b1);
      begin
        @(posedge clk);
        repeat (4125) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    @(negedge clk);
    check("rdc_dat",  dat,     32'h1E);
    check("rdc_done", done,    32'h1);
    check("rdc_ovr",  overrun, 32'h0);
    idle(10);

    // Reset during data bit 4; hold reset until the aborted frame ends
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (5 * c_CPB + 200) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("mrst_dat",  dat,  32'h0);
        check("mrst_done", done, 32'h0);
        check("mrst_busy", busy, 32'h0);
      end
    join
    @(posedge clk); #1 rst = 1'b0;
    idle(10);
    send_frame(8'h55, 1'b1);
    @(negedge clk);
    check("b55_dat",  dat,       32'h55);
    check("b55_done", done,      32'h1);
    check("b55_ferr", frame_err, 32'h0);
    check("b55_ovr",  overrun,   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
